// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor processing DIGIT bits per clock
// Ports: clk, rst_n (async active-low); start/sub/a/b/cin request, sampled in IDLE or DONE;
//        busy (RUN state), done (one-cycle pulse), s/cout/ovf registered result held until next done.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0]   dsum;
  logic             c_msb, run, accept, last;

  assign run    = state_q == RUN;
  assign accept = start && !run;
  assign last   = run && cnt_q == CW'(N - 1);
  assign dsum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  // Carry into the digit's top bit; on the last digit this is the carry into bit WIDTH-1.
  assign c_msb  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];

  always_comb begin
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    a_d     = accept ? a : run ? a_q >> DIGIT : a_q;
    b_d     = accept ? (sub ? ~b : b) : run ? b_q >> DIGIT : b_q;
    c_d     = accept ? (sub | cin) : run ? dsum[DIGIT] : c_q;
    acc_d   = run ? (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT)) : acc_q;
    s_d     = last ? acc_d : s_q;
    cout_d  = last ? dsum[DIGIT] : cout_q;
    ovf_d   = last ? c_msb ^ dsum[DIGIT] : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = run;
  assign done = state_q == DONE;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder across several WIDTH/DIGIT configurations
module tb_serial_adder;
  localparam int NI = 6;

  function automatic int wof(int i);
    return i == 4 ? 16 : i == 5 ? 32 : 8;
  endfunction
  function automatic int dof(int i);
    return i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 4 : 8;
  endfunction
  function automatic int nof(int i);
    return wof(i) / dof(i);
  endfunction

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk, rst_n;
  logic        start_v[NI], sub_v[NI], cin_v[NI];
  logic [31:0] a_v[NI], b_v[NI], s_v[NI];
  logic        busy_v[NI], done_v[NI], cout_v[NI], ovf_v[NI];
  exp_t        sb[NI][$];
  exp_t        held[NI];
  int          cyc = 0, tests = 0, fails = 0;

  for (genvar g = 0; g < NI; g++) begin : gd
    localparam int W = wof(g);
    localparam int D = dof(g);
    logic [W-1:0] s_w;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .sub(sub_v[g]),
      .a(a_v[g][W-1:0]), .b(b_v[g][W-1:0]), .cin(cin_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .s(s_w), .cout(cout_v[g]), .ovf(ovf_v[g])
    );
    assign s_v[g] = 32'(s_w);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d (W=%0d D=%0d) cyc=%0d: got %h expected %h", n, i, wof(i), dof(i), cyc, act, exp);
    end
  endfunction

  // Reference: whole-word arithmetic; overflow judged from the true signed result.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin, int due);
    exp_t e;
    longint unsigned m, ua, ub, full;
    longint sa, sbv, ts, hi;
    m    = (64'd1 << w) - 1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    hi   = longint'(64'd1 << (w - 1));
    sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - 2 * hi : longint'(ua);
    sbv  = ((ub >> (w - 1)) != 0) ? longint'(ub) - 2 * hi : longint'(ub);
    full = sub ? ua + (~ub & m) + 1 : ua + ub + (cin ? 1 : 0);
    ts   = sub ? sa - sbv : sa + sbv + (cin ? 1 : 0);
    e.s    = 32'(full & m);
    e.cout = full[w];
    e.ovf  = ts >= hi || ts < -hi;
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        exp_t e;
        if (done_v[i]) begin
          if (sb[i].size() == 0) chk("unexpected done", i, 1, 0);
          else begin
            e = sb[i].pop_front();
            chk("done latency", i, cyc, e.due);
            held[i] = e;
          end
        end else if (sb[i].size() > 0 && cyc >= sb[i][0].due) begin
          chk("missing done", i, 0, 1);
          held[i] = sb[i].pop_front();
        end
        chk("busy", i, busy_v[i], sb[i].size() > 0 && cyc >= sb[i][0].due - nof(i));
        chk("s", i, s_v[i], held[i].s);
        chk("cout", i, cout_v[i], held[i].cout);
        chk("ovf", i, ovf_v[i], held[i].ovf);
      end
    end
  end

  // Called in the low clock phase; leaves the bench in the low phase of the following cycle.
  task automatic go(int i, logic [31:0] a, logic [31:0] b, logic sub, logic cin, bit acc);
    a_v[i] = a; b_v[i] = b; sub_v[i] = sub; cin_v[i] = cin; start_v[i] = 1'b1;
    if (acc) sb[i].push_back(model(wof(i), a, b, sub, cin, cyc + 1 + nof(i)));
    @(negedge clk); #2;
    start_v[i] = 1'b0;
    a_v[i] = $urandom; b_v[i] = $urandom; sub_v[i] = 1'($urandom); cin_v[i] = 1'($urandom);
  endtask

  task automatic wait_idle(int i);
    int k;
    for (k = 0; k < 100 && sb[i].size() != 0; k++) begin
      @(negedge clk); #2;
    end
    if (k == 100) chk("idle timeout", i, 0, 1);
  endtask

  task automatic wait_done(int i);
    int k;
    for (k = 0; k < 100 && !done_v[i]; k++) begin
      @(negedge clk); #2;
    end
    if (k == 100) chk("done timeout", i, 0, 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NI; i++) begin
      sb[i].delete();
      held[i] = '{s: 32'd0, cout: 1'b0, ovf: 1'b0, due: 0};
    end
  endtask

  task automatic chk_zero(string n);
    for (int i = 0; i < NI; i++) begin
      chk({n, " busy"}, i, busy_v[i], 0);
      chk({n, " done"}, i, done_v[i], 0);
      chk({n, " s"}, i, s_v[i], 0);
      chk({n, " cout"}, i, cout_v[i], 0);
      chk({n, " ovf"}, i, ovf_v[i], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 0; sub_v[i] = 0; cin_v[i] = 0; a_v[i] = 0; b_v[i] = 0;
    end
    clear_all();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #2;
    // 8/2: addition with signed overflow, then subtraction with borrow
    go(1, 32'h5A, 32'h33, 0, 0, 1);
    wait_idle(1);
    chk("5A+33 s", 1, s_v[1], 32'h8D);
    chk("5A+33 cout", 1, cout_v[1], 0);
    chk("5A+33 ovf", 1, ovf_v[1], 1);
    go(1, 32'h10, 32'h20, 1, 1, 1);
    wait_idle(1);
    chk("10-20 s", 1, s_v[1], 32'hF0);
    chk("10-20 cout", 1, cout_v[1], 0);
    chk("10-20 ovf", 1, ovf_v[1], 0);
    // 8/1: carry-in with wraparound, then positive overflow
    go(0, 32'hFF, 32'h01, 0, 1, 1);
    wait_idle(0);
    chk("FF+01+1 s", 0, s_v[0], 32'h01);
    chk("FF+01+1 cout", 0, cout_v[0], 1);
    chk("FF+01+1 ovf", 0, ovf_v[0], 0);
    go(0, 32'h7F, 32'h01, 0, 0, 1);
    wait_idle(0);
    chk("7F+01 s", 0, s_v[0], 32'h80);
    chk("7F+01 cout", 0, cout_v[0], 0);
    chk("7F+01 ovf", 0, ovf_v[0], 1);
    // 8/4: start during RUN ignored, then back-to-back start in the DONE cycle
    go(2, 32'h12, 32'h34, 0, 0, 1);
    go(2, 32'hFF, 32'hFF, 0, 0, 0);
    wait_done(2);
    chk("first result", 2, s_v[2], 32'h46);
    chk("in done cycle", 2, done_v[2], 1);
    go(2, 32'h01, 32'h01, 0, 0, 1);
    wait_idle(2);
    chk("b2b result", 2, s_v[2], 32'h02);
    // Reset in the middle of an 8/1 operation
    go(0, 32'h5A, 32'h33, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    clear_all();
    chk_zero("mid-op reset");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    go(0, 32'h5A, 32'h33, 0, 0, 1);
    wait_idle(0);
    chk("after reset s", 0, s_v[0], 32'h8D);
    // Randomised sweep with ignored and back-to-back starts
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 25; n++) begin
        go(i, $urandom, $urandom, 1'($urandom), 1'($urandom), 1);
        if ($urandom_range(1, 0) == 1) go(i, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
        if ($urandom_range(1, 0) == 1) wait_done(i);
        else begin
          wait_idle(i);
          repeat ($urandom_range(2, 0)) begin
            @(negedge clk); #2;
          end
        end
      end
      wait_idle(i);
    end
    repeat (3) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
